// File: rtl/axis_snapshot_pkg.sv
// Shared types and helpers for the AXI4-Stream snapshot buffer.
// Optional decimation is enabled by defining AXIS_SNAPSHOT_DECIM_EN.
package axis_snapshot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } snap_state_t;

    localparam int DECIM_W = 16;

    // Address width for a storage of `depth` entries; never below one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_snapshot_ram.sv
// Sample storage: one synchronous write port, one registered read port.
// The read register returns the old word on a same-address write (read-before-write).
module axis_snapshot_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto RAM primitives; contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_snapshot_buffer.sv
// Multi-sample AXI4-Stream capture buffer with one-shot and rolling modes.
// Define AXIS_SNAPSHOT_DECIM_EN to add the cfg_decim input (capture every N+1-th beat).
module axis_snapshot_buffer
    import axis_snapshot_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH            = 16,
    parameter     ALWAYS_READY     = "TRUE"
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             m_axis_tready,
    input  logic                             cfg_rolling,
`ifdef AXIS_SNAPSHOT_DECIM_EN
    input  logic [DECIM_W-1:0]               cfg_decim,
`endif
    input  logic                             arm,
    input  logic                             stop,
    input  logic [addr_width(DEPTH)-1:0]     rd_addr,
    output logic [AXIS_TDATA_WIDTH-1:0]      rd_data,
    output logic [AXIS_TDATA_WIDTH-1:0]      data,
    output logic [addr_width(DEPTH):0]       count,
    output logic                             busy,
    output logic                             done
);

    localparam int            AW         = addr_width(DEPTH);
    localparam bit            READY_TIED = (ALWAYS_READY == "TRUE");
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_MAX    = AW'(DEPTH - 1);

    snap_state_t     state, state_next;
    logic [AW-1:0]   wr_ptr;
    logic            wrapped;
    logic            rolling;
    logic            beat;
    logic            take;
    logic            capture_en;
    logic [AW-1:0]   base;
    logic [AW-1:0]   ram_rd_addr;

    assign s_axis_tready = READY_TIED ? 1'b1 : m_axis_tready;
    assign beat          = s_axis_tvalid & s_axis_tready;

`ifdef AXIS_SNAPSHOT_DECIM_EN
    logic [DECIM_W-1:0] decim_cfg;
    logic [DECIM_W-1:0] decim_cnt;

    assign take = (decim_cnt == '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            decim_cfg <= '0;
            decim_cnt <= '0;
        end else if (arm) begin
            decim_cfg <= cfg_decim;
            decim_cnt <= '0;
        end else if (state == CAPTURE && beat) begin
            decim_cnt <= (decim_cnt == decim_cfg) ? '0 : decim_cnt + DECIM_W'(1);
        end
    end
`else
    assign take = 1'b1;
`endif

    // arm has priority: a beat in the arm cycle belongs to neither the old nor the new capture
    assign capture_en = (state == CAPTURE) & beat & take & ~arm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = CAPTURE;
        end else if (state == CAPTURE) begin
            if (capture_en && !rolling && (count == DEPTH_CNT - CNT_ONE)) begin
                state_next = DONE;
            end else if (stop && rolling) begin
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            rolling <= 1'b0;
            data    <= '0;
        end else if (arm) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            rolling <= cfg_rolling;
        end else if (capture_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            data   <= s_axis_tdata;
            if (wr_ptr == PTR_MAX) begin
                wrapped <= 1'b1;
            end
            if (count != DEPTH_CNT) begin
                count <= count + CNT_ONE;
            end
        end
    end

    // Once wrapped, the oldest sample sits at the next write position.
    assign base        = wrapped ? wr_ptr : '0;
    assign ram_rd_addr = base + rd_addr;

    axis_snapshot_ram #(
        .WIDTH (AXIS_TDATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (capture_en),
        .wr_addr (wr_ptr),
        .wr_data (s_axis_tdata),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );

    assign busy = (state == CAPTURE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_axis_snapshot_buffer.sv
// Directed self-checking bench for axis_snapshot_buffer (DEPTH = 16, 32-bit samples).
// Covers decimation as well when AXIS_SNAPSHOT_DECIM_EN is defined.
module tb_axis_snapshot_buffer;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic        cfg_rolling;
    logic [15:0] cfg_decim;
    logic        arm;
    logic        stop;
    logic [3:0]  rd_addr;

    // Blocking-mode DUT (ready follows m_axis_tready)
    logic        s_axis_tready;
    logic [31:0] rd_data;
    logic [31:0] data;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    // Always-ready DUT sharing all inputs
    logic        ar_tready;
    logic [31:0] ar_rd_data;
    logic [31:0] ar_data;
    logic [4:0]  ar_count;
    logic        ar_busy;
    logic        ar_done;

    int n_pass  = 0;
    int n_total = 0;

    axis_snapshot_buffer #(
        .AXIS_TDATA_WIDTH (32),
        .DEPTH            (16),
        .ALWAYS_READY     ("FALSE")
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .cfg_rolling   (cfg_rolling),
`ifdef AXIS_SNAPSHOT_DECIM_EN
        .cfg_decim     (cfg_decim),
`endif
        .arm           (arm),
        .stop          (stop),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .data          (data),
        .count         (count),
        .busy          (busy),
        .done          (done)
    );

    axis_snapshot_buffer #(
        .AXIS_TDATA_WIDTH (32),
        .DEPTH            (16),
        .ALWAYS_READY     ("TRUE")
    ) dut_ar (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (ar_tready),
        .m_axis_tready (m_axis_tready),
        .cfg_rolling   (cfg_rolling),
`ifdef AXIS_SNAPSHOT_DECIM_EN
        .cfg_decim     (cfg_decim),
`endif
        .arm           (arm),
        .stop          (stop),
        .rd_addr       (rd_addr),
        .rd_data       (ar_rd_data),
        .data          (ar_data),
        .count         (ar_count),
        .busy          (ar_busy),
        .done          (ar_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_arm(input logic roll);
        cfg_rolling = roll;
        arm         = 1'b1;
        step();
        arm         = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic read_at(input int a, output logic [31:0] v);
        rd_addr = 4'(a);
        step();
        v = rd_data;
    endtask

    initial begin
        logic [31:0] v;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cfg_rolling   = 1'b0;
        cfg_decim     = '0;
        arm           = 1'b0;
        stop          = 1'b0;
        rd_addr       = '0;

        // Reset values and ready behaviour
        #3;
        check("rst_data",    data, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count",   32'(count), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_done",    32'(done), 0);
        check("rdy_follow_1", 32'(s_axis_tready), 1);
        m_axis_tready = 1'b0;
        #1;
        check("rdy_follow_0", 32'(s_axis_tready), 0);
        check("rdy_tied",     32'(ar_tready), 1);
        m_axis_tready = 1'b1;
        #1;
        check("rdy_follow_back", 32'(s_axis_tready), 1);
        step();
        aresetn = 1'b1;
        step();

        // One-shot: a beat in the arm cycle is dropped, 16 of 20 beats stored
        s_axis_tdata  = 32'd99;
        s_axis_tvalid = 1'b1;
        do_arm(1'b0);
        s_axis_tvalid = 1'b0;
        check("os_busy_after_arm",  32'(busy), 1);
        check("os_count_after_arm", 32'(count), 0);
        for (int i = 1; i <= 15; i++) send(32'(i));
        check("os_count_15", 32'(count), 15);
        check("os_busy_15",  32'(busy), 1);
        check("os_done_15",  32'(done), 0);
        send(32'd16);
        check("os_done_16",  32'(done), 1);
        check("os_busy_16",  32'(busy), 0);
        check("os_count_16", 32'(count), 16);
        check("os_data_16",  data, 16);
        for (int i = 17; i <= 20; i++) send(32'(i));
        check("os_data_after", data, 16);
        check("os_count_after", 32'(count), 16);
        check("os_ar_count", 32'(ar_count), 16);
        for (int i = 0; i < 16; i++) begin
            read_at(i, v);
            check($sformatf("os_rd_%0d", i), v, 32'(i + 1));
        end

        // Rolling: 40 beats, stop coincides with the 40th which is still stored
        do_arm(1'b1);
        for (int i = 1; i <= 39; i++) send(32'(i));
        check("roll_busy_39",  32'(busy), 1);
        check("roll_count_39", 32'(count), 16);
        s_axis_tdata  = 32'd40;
        s_axis_tvalid = 1'b1;
        stop          = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        stop          = 1'b0;
        check("roll_done",  32'(done), 1);
        check("roll_busy",  32'(busy), 0);
        check("roll_count", 32'(count), 16);
        check("roll_data",  data, 40);
        read_at(0, v);
        check("roll_rd_0", v, 25);
        read_at(7, v);
        check("roll_rd_7", v, 32);
        read_at(15, v);
        check("roll_rd_15", v, 40);

        // arm + stop together: arm wins; then gaps and backpressure
        cfg_rolling = 1'b0;
        arm         = 1'b1;
        stop        = 1'b1;
        step();
        arm         = 1'b0;
        stop        = 1'b0;
        check("armstop_busy",  32'(busy), 1);
        check("armstop_done",  32'(done), 0);
        check("armstop_count", 32'(count), 0);
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd101; step();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = 32'd102; step();
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'd103; step();
        s_axis_tvalid = 1'b0; step();
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd104; step();
        m_axis_tready = 1'b1; s_axis_tdata = 32'd105; step();
        s_axis_tvalid = 1'b0;
        check("gap_count",    32'(count), 2);
        check("gap_data",     data, 105);
        check("gap_ar_count", 32'(ar_count), 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("oneshot_stop_ignored", 32'(busy), 1);
        read_at(0, v);
        check("gap_rd_0", v, 103);
        read_at(1, v);
        check("gap_rd_1", v, 105);

        // Re-arm mid-capture after 5 beats; the beat in the arm cycle is dropped
        for (int i = 106; i <= 108; i++) send(32'(i));
        check("rearm_count_5", 32'(count), 5);
        s_axis_tdata  = 32'd200;
        s_axis_tvalid = 1'b1;
        do_arm(1'b0);
        s_axis_tvalid = 1'b0;
        check("rearm_count_0", 32'(count), 0);
        check("rearm_busy",    32'(busy), 1);
        send(32'd201);
        check("rearm_count_1", 32'(count), 1);
        read_at(0, v);
        check("rearm_rd_0", v, 201);

        // Asynchronous reset mid-capture
        aresetn = 1'b0;
        #2;
        check("arst_count",   32'(count), 0);
        check("arst_busy",    32'(busy), 0);
        check("arst_done",    32'(done), 0);
        check("arst_data",    data, 0);
        check("arst_rd_data", rd_data, 0);
        #1;
        aresetn = 1'b1;
        step();
        read_at(0, v);
        check("arst_mem_kept", v, 201);
        send(32'd300);
        check("idle_no_capture", 32'(count), 0);
        check("idle_data",       data, 0);

`ifdef AXIS_SNAPSHOT_DECIM_EN
        // Decimation by 3: stores 1, 4, 7, ..., 46
        cfg_decim = 16'd2;
        do_arm(1'b0);
        for (int i = 1; i <= 45; i++) send(32'(i));
        check("dec_busy_45",  32'(busy), 1);
        check("dec_count_45", 32'(count), 15);
        send(32'd46);
        check("dec_done_46",  32'(done), 1);
        check("dec_data_46",  data, 46);
        send(32'd47);
        send(32'd48);
        check("dec_count_end", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            read_at(i, v);
            check($sformatf("dec_rd_%0d", i), v, 32'(1 + 3 * i));
        end
        cfg_decim = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_snapshot_buffer.md
# axis_snapshot_buffer

Parametrised multi-sample capture buffer on an AXI4-Stream slave, successor to the single-word snapshot core. On `arm`, it records up to DEPTH consecutive accepted beats into internal storage. Two modes:
- one-shot: stops when full.
- rolling: overwrites circularly until `stop`.

Sits after ADC/DSP stream blocks. Software reads samples back through a random-access read port; `data` keeps the last-captured-word output for drop-in use.

## Interface
- `AXIS_TDATA_WIDTH`, 32, sample width in bits.
- `DEPTH`, 16, number of stored samples; power of two, 2..1024.
- `ALWAYS_READY`, "TRUE": `s_axis_tready` is tied 1; otherwise it follows `m_axis_tready`.
- `aclk` in 1: single clock; all logic on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in AXIS_TDATA_WIDTH: sample stream.
- `s_axis_tvalid` in 1: stream valid.
- `s_axis_tready` out 1: stream ready, per `ALWAYS_READY`.
- `m_axis_tready` in 1: downstream ready, used only in blocking mode.
- `cfg_rolling` in 1: 0 = one-shot, 1 = rolling. Sampled only on `arm`.
- `arm` in 1: one-cycle pulse that starts a capture.
- `stop` in 1: one-cycle pulse that freezes a rolling capture.
- `rd_addr` in clog2(DEPTH): read index; 0 = oldest stored sample.
- `rd_data` out AXIS_TDATA_WIDTH: sample at `rd_addr`, registered.
- `data` out AXIS_TDATA_WIDTH: most recently captured sample.
- `count` out clog2(DEPTH)+1: samples stored, saturating at DEPTH.
- `busy` out 1: capture in progress.
- `done` out 1: capture complete and buffer frozen.

## Operation
- **Beat:** `s_axis_tvalid & s_axis_tready`. Only beats are considered for capture.
- **States:** IDLE, CAPTURE, DONE. Reset enters IDLE.
- **IDLE/DONE + arm → CAPTURE:**
  - clear `wr_ptr`, `count` and `wrapped`;
  - latch `cfg_rolling`;
  - clear the decimation counter.
- **CAPTURE, captured beat:**
  - write `mem[wr_ptr]`;
  - `wr_ptr` increments modulo DEPTH;
  - `count` increments, saturating at DEPTH;
  - `data` takes the beat value.
- **One-shot:** the capture that brings `count` to DEPTH moves to DONE. Later beats are ignored.
- **Rolling:** `wr_ptr` wraps and `wrapped` is set. `stop` → DONE; a beat in the same cycle as `stop` is still captured.
- **Boundary rules:**
  - `stop` in one-shot mode, or outside CAPTURE, is ignored.
  - `arm` during CAPTURE restarts the capture; stored contents become invalid.
  - `arm` and `stop` in the same cycle: `arm` wins.
- **Read mapping:** `rd_data` = `mem[(base + rd_addr) mod DEPTH]`.
  - `base` = `wr_ptr` when `wrapped`, else 0.
  - Addresses ≥ `count` return stale contents; no error is flagged.
- **Status:** `busy` = (state == CAPTURE); `done` = (state == DONE).
- **Reset mid-capture:** immediately returns to IDLE and clears all status. `mem` contents are not cleared.

## Timing
- **Reset values:** `data` = 0, `rd_data` = 0, `count` = 0, `busy` = 0, `done` = 0. `s_axis_tready` is 1 when ALWAYS_READY = "TRUE", else it follows `m_axis_tready`.
- **`arm` sampled at edge n:** `busy` = 1 after edge n. A beat present in cycle n is not captured.
- **Beat captured at edge n:** `data` and `count` update after edge n.
- **DEPTH-th one-shot beat at edge n:** `busy` = 0 and `done` = 1 after edge n.
- **Read latency:** `rd_data` follows `rd_addr` with 1 cycle of latency, in any state, including concurrently with a write to the same location (read-before-write: returns the old word).
- `s_axis_tready` is combinational; the block never applies backpressure on its own.

## Configuration
- Macro `AXIS_SNAPSHOT_DECIM_EN`.
- **Defined:**
  - adds input `cfg_decim` [15:0], sampled on `arm`;
  - in CAPTURE, only every (`cfg_decim`+1)-th beat is captured, starting with the first beat after `arm`;
  - the decimation counter counts beats only and clears on `arm`;
  - `cfg_decim` = 0 is equivalent to the macro being undefined.
- **Undefined:** port absent; every beat in CAPTURE is captured.

## Structure
- Package `axis_snapshot_pkg`:
  - state enum `snap_state_t` (IDLE, CAPTURE, DONE);
  - the decimation counter width constant (16);
  - the clog2-based address-width helper.
- Sub-module `axis_snapshot_ram`: DEPTH × AXIS_TDATA_WIDTH storage with one synchronous write port and one registered read port. Inferable as distributed or block RAM.
- Top level: FSM, pointers, count, decimation and read-address mapping.

## Test plan
- **Reset/ready:** assert `aresetn` = 0 mid-capture → all outputs 0, state IDLE. With ALWAYS_READY = "FALSE", toggle `m_axis_tready` → `s_axis_tready` mirrors it.
- **One-shot, DEPTH = 16:** `arm`, then 20 beats with values 1..20 → `done` after the 16th; `count` = 16; `rd_addr` 0..15 returns 1..16; `data` = 16.
- **Rolling:** `arm` with `cfg_rolling` = 1, 40 beats (1..40), then `stop` → `count` = 16; `rd_addr` 0 → 25, `rd_addr` 15 → 40; `done` = 1.
- **Gaps and collisions:**
  - beats with `tvalid` gaps and `tready` low (blocking) → only handshaked beats are stored;
  - a beat in the `arm` cycle is not stored;
  - `arm` + `stop` in the same cycle → capture starts.
- **Re-arm mid-capture:** after 5 beats, `arm` again → `count` restarts at 0; the next beat lands at `rd_addr` 0.
- **Decimation (macro defined):** `cfg_decim` = 2, beats 1..48, one-shot → stored values 1, 4, 7, …, 46; `done` after the 46th beat.
